ysyx_23060236_axi_rd_master: RTL and testbench

AXI4-lite read-channel initiator (AR + R) used by the core's load path to read memory-mapped slaves such as the CLINT mtime registers and the SRAM/UART bridge. It accepts one load request at a time from the LSU, issues a single-beat read, aligns and optionally sign-extends the returned data by access size, and reports the result with an error flag. It is the master end of the same AR/R handshake that the slaves implement.

---
 rtl/ysyx_23060236_axi_rd_pkg.sv | 30 +++
 rtl/ysyx_23060236_axi_rd_master_load_ext.sv | 25 ++
 rtl/ysyx_23060236_axi_rd_master.sv | 145 ++++++++++++++
 tb/tb_ysyx_23060236_axi_rd_master.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060236_axi_rd_pkg.sv
// Shared definitions for the AXI4-lite read master: FSM states,
// load size encodings, the OKAY response code and the alignment rule.
package ysyx_23060236_axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] RRESP_OKAY = 2'd0;

  // Size 3 is reserved and always rejected as misaligned.
  function automatic logic is_misaligned(input logic [1:0] offset, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_23060236_axi_rd_master_load_ext.sv
// Load data formatter: shifts the bus word down by the byte offset and
// truncates/extends it to the access size. Purely combinational.
module ysyx_23060236_load_ext
  import ysyx_23060236_axi_rd_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Align the addressed bytes to bit 0, then extend according to size.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SZ_BYTE: data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_23060236_axi_rd_master.sv
// AXI4-lite read initiator: one LSU load at a time, single-beat AR/R, aligned/extended result.
// Latency: 3 cycles accept-to-response with a zero-stall slave; misaligned requests answer in 1.
// Optional per-phase timeout when YSYX_23060236_AXI_RD_TIMEOUT_EN is defined; otherwise waits forever.
module ysyx_23060236_axi_rd_master
  import ysyx_23060236_axi_rd_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] ext_data;
  logic        tmo_hit;
  logic        req_mis;

  assign req_mis = is_misaligned(req_addr[1:0], req_size);

  ysyx_23060236_load_ext u_load_ext (
    .rdata     (rdata),
    .offset    (addr_q[1:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .data      (ext_data)
  );

`ifdef YSYX_23060236_AXI_RD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

  // Phase cycle counter: restarts whenever the FSM changes state, counts while waiting on the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != state_nxt) begin
      tmo_cnt <= '0;
    end else if (state == ST_AR || state == ST_R) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a pending handshake always wins over a timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = req_mis ? ST_RESP : ST_AR;
      ST_AR: begin
        if (arready)      state_nxt = ST_R;
        else if (tmo_hit) state_nxt = ST_RESP;
      end
      ST_R: begin
        if (rvalid)       state_nxt = ST_RESP;
        else if (tmo_hit) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch and registered response capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      size_q    <= SZ_BYTE;
      signed_q  <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            size_q   <= req_size;
            signed_q <= req_signed;
            if (req_mis) begin
              resp_err  <= 1'b1;
              resp_data <= '0;
            end
          end
        end
        ST_AR: begin
          if (!arready && tmo_hit) begin
            resp_err  <= 1'b1;
            resp_data <= '0;
          end
        end
        ST_R: begin
          if (rvalid) begin
            resp_err  <= (rresp != RRESP_OKAY);
            resp_data <= (rresp == RRESP_OKAY) ? ext_data : 32'd0;
          end else if (tmo_hit) begin
            resp_err  <= 1'b1;
            resp_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // All handshake outputs decode the registered state; req_ready stays low while reset is held.
  assign req_ready  = (state == ST_IDLE) && !reset;
  assign arvalid    = (state == ST_AR);
  assign rready     = (state == ST_R);
  assign resp_valid = (state == ST_RESP);
  assign araddr     = addr_q;

endmodule

// File: tb/tb_ysyx_23060236_axi_rd_master.sv
module tb_ysyx_23060236_axi_rd_master;

  localparam int TMO = 16;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  ysyx_23060236_axi_rd_master #(.TIMEOUT(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_stall;
    int          r_stall;
    bit          hang;
  } sl_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
    int          acc;
    int          lat;
  } ex_t;

  sl_t sl_q[$];
  ex_t exp_q[$];
  int total = 0;
  int bad = 0;
  logic [31:0] cur_addr = 0;
  bit seen_ar = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at cycle %0d", name, act, want, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
  endtask

  // Architectural load result: take the addressed bytes and widen them.
  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [1:0] sz, input bit sg);
    longint v;
    v = rd >> (8 * off);
    if (sz == 2'd0) begin
      v = v % 256;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (sg && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  // Slave: for each accepted address, stall AR and R as scripted, then return the beat.
  task automatic slave_loop();
    sl_t s;
    forever begin
      @(negedge clock);
      if (!reset && arvalid && sl_q.size() != 0) begin
        s = sl_q.pop_front();
        if (!s.hang) begin
          repeat (s.ar_stall) @(negedge clock);
          arready = 1'b1;
          @(negedge clock);
          arready = 1'b0;
          repeat (s.r_stall) @(negedge clock);
          rvalid = 1'b1;
          rdata  = s.rdata;
          rresp  = s.rresp;
          @(negedge clock);
          rvalid = 1'b0;
          rdata  = $urandom;
          rresp  = 2'($urandom);
        end
      end
    end
  endtask

  // Monitor: scoreboard pop on each response plus bus-side invariants.
  task automatic monitor_loop();
    ex_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_resp");
          end else begin
            e = exp_q.pop_front();
            chk("resp_data", resp_data, e.data);
            chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            chk("latency", cyc - e.acc, e.lat);
          end
        end
        if (arvalid) begin
          seen_ar = 1;
          if (araddr !== cur_addr) chk("araddr", araddr, cur_addr);
        end
        if (arvalid && rready) chk("ar_r_overlap", {31'd0, rready}, 32'd0);
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [1:0] sz, input bit sg);
    cur_addr   = a;
    seen_ar    = 0;
    req_valid  = 1'b1;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    @(negedge clock);
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [1:0] sz, input bit sg,
                        input logic [31:0] rd, input logic [1:0] rr,
                        input int ars, input int rs, input bit hang);
    bit mis;
    ex_t e;
    sl_t s;
    int n;
    mis = (sz == 2'd3) || ((a % (32'd1 << sz)) != 0);
    wait_ready();
    if (!req_ready) begin
      fail_now("req_ready_wait");
      return;
    end
    if (!mis) begin
      s.rdata = rd; s.rresp = rr; s.ar_stall = ars; s.r_stall = rs; s.hang = hang;
      sl_q.push_back(s);
    end
    e.acc  = cyc;
    e.lat  = mis ? 1 : (hang ? TMO + 1 : 3 + ars + rs);
    e.err  = mis || hang || (rr != 2'd0);
    e.data = e.err ? 32'd0 : ref_load(rd, a[1:0], sz, sg);
    exp_q.push_back(e);
    drive_req(a, sz, sg);
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now("resp_wait");
      exp_q.delete();
    end
    if (mis) chk("no_ar_on_misalign", {31'd0, seen_ar}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = 0; req_size = 0; req_signed = 0;
    arready = 1'b0; rvalid = 1'b0; rdata = 0; rresp = 0;
    fork
      slave_loop();
      monitor_loop();
    join_none

    repeat (3) @(negedge clock);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_req_ready_held", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    @(negedge clock);

    // Directed cases.
    do_req(32'h0200_BFF8, 2'd2, 1'b0, 32'h1234_5678, 2'd0, 0, 0, 1'b0);
    do_req(32'h8000_0003, 2'd0, 1'b1, 32'h80FF_0000, 2'd0, 0, 0, 1'b0);
    do_req(32'h8000_0003, 2'd0, 1'b0, 32'h80FF_0000, 2'd0, 0, 0, 1'b0);
    do_req(32'h8000_0001, 2'd1, 1'b1, 32'hDEAD_BEEF, 2'd0, 0, 0, 1'b0);
    do_req(32'h8000_0002, 2'd1, 1'b1, 32'h9ABC_0000, 2'd0, 1, 2, 1'b0);
    do_req(32'h8000_0010, 2'd3, 1'b0, 32'h1111_1111, 2'd0, 0, 0, 1'b0);
    do_req(32'h1000_0000, 2'd2, 1'b0, 32'hCAFE_F00D, 2'd2, 5, 3, 1'b0);

    // Reset while waiting in R: no response, bus outputs drop at once.
    begin
      sl_t s;
      wait_ready();
      s.rdata = 32'h5555_AAAA; s.rresp = 2'd0; s.ar_stall = 0; s.r_stall = 8; s.hang = 1'b0;
      sl_q.push_back(s);
      drive_req(32'h2000_0004, 2'd2, 1'b0);
      @(negedge clock);
      chk("in_r_rready", {31'd0, rready}, 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_rready", {31'd0, rready}, 32'd0);
      chk("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
      chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
      repeat (12) @(negedge clock);
    end
    do_req(32'h2000_0008, 2'd2, 1'b0, 32'h0BAD_CAFE, 2'd0, 0, 0, 1'b0);

    // Slave that never accepts the address.
`ifdef YSYX_23060236_AXI_RD_TIMEOUT_EN
    do_req(32'h3000_0000, 2'd2, 1'b0, 32'h0, 2'd0, 0, 0, 1'b1);
`else
    begin
      sl_t s;
      wait_ready();
      s.rdata = 0; s.rresp = 0; s.ar_stall = 0; s.r_stall = 0; s.hang = 1'b1;
      sl_q.push_back(s);
      drive_req(32'h3000_0000, 2'd2, 1'b0);
      repeat (99) @(negedge clock);
      chk("no_tmo_arvalid_c100", {31'd0, arvalid}, 32'd1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
    end
`endif

    // Randomized loads.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [1:0]  rr;
      a  = $urandom;
      rr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      do_req(a, 2'($urandom), 1'($urandom), $urandom, rr,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
